// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that shares one data-memory channel
// among NUM_CONSUMERS LSUs, one transaction at a time
// (grant -> memory access -> one-cycle ack -> wait for release).
// Optional build macro DATA_MEM_ARB_STATS_EN adds read/write/stall counters.
module data_mem_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 17,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic                                mem_read_valid,
  output logic [ADDR_WIDTH-1:0]               mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_WIDTH-1:0]               mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_WIDTH-1:0]               mem_write_address,
  output logic [DATA_WIDTH-1:0]               mem_write_data,
  input  logic                                mem_write_ready,
`ifdef DATA_MEM_ARB_STATS_EN
  output logic [31:0]                         stat_reads,
  output logic [31:0]                         stat_writes,
  output logic [31:0]                         stat_stall,
`endif
  output logic                                busy
);

  localparam int unsigned IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEM_RD  = 3'd1;
  localparam logic [2:0] S_MEM_WR  = 3'd2;
  localparam logic [2:0] S_RESPOND = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]                          r_state;
  logic [2:0]                          w_state_nxt;
  logic [IDX_W-1:0]                    r_ptr;
  logic [IDX_W-1:0]                    r_idx;
  logic                                r_is_wr;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic [DATA_WIDTH-1:0]               r_wdata;
  logic                                r_mem_read_valid;
  logic                                r_mem_write_valid;
  logic                                r_busy;
  logic [NUM_CONSUMERS-1:0]            r_rd_ready;
  logic [NUM_CONSUMERS-1:0]            r_wr_ready;
  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] r_rd_data;

  logic [NUM_CONSUMERS-1:0]            w_req;
  logic                                w_grant_found;
  logic [IDX_W-1:0]                    w_grant_idx;
  logic                                w_grant_is_wr;
  logic [ADDR_WIDTH-1:0]               w_grant_addr;
  logic [DATA_WIDTH-1:0]               w_grant_wdata;
  logic                                w_served_valid;
  int unsigned                         w_scan;

  assign w_req = consumer_read_valid | consumer_write_valid;

  // Round-robin search starting one past the last winner, wrapping N-1 -> 0
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int unsigned k = 1; k <= NUM_CONSUMERS; k++) begin
      w_scan = 32'(r_ptr) + k;
      if (w_scan >= NUM_CONSUMERS) w_scan = w_scan - NUM_CONSUMERS;
      if (!w_grant_found && w_req[IDX_W'(w_scan)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDX_W'(w_scan);
      end
    end
  end

  // Winner's request type (write has priority) and payload
  always_comb begin
    w_grant_is_wr = 1'b0;
    w_grant_addr  = '0;
    w_grant_wdata = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (IDX_W'(i) == w_grant_idx) begin
        w_grant_is_wr = consumer_write_valid[i];
        w_grant_addr  = consumer_write_valid[i] ? consumer_write_address[i*ADDR_WIDTH +: ADDR_WIDTH]
                                                : consumer_read_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_grant_wdata = consumer_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_served_valid = r_is_wr ? consumer_write_valid[r_idx] : consumer_read_valid[r_idx];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_grant_found) w_state_nxt = w_grant_is_wr ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_read_ready) w_state_nxt = S_RESPOND;
      S_MEM_WR:  if (mem_write_ready) w_state_nxt = S_RESPOND;
      S_RESPOND: w_state_nxt = S_RELEASE;
      S_RELEASE: if (!w_served_valid) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Grant latching, memory request, read capture and one-cycle acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr             <= IDX_W'(NUM_CONSUMERS - 1);
      r_idx             <= '0;
      r_is_wr           <= 1'b0;
      r_addr            <= '0;
      r_wdata           <= '0;
      r_mem_read_valid  <= 1'b0;
      r_mem_write_valid <= 1'b0;
      r_busy            <= 1'b0;
      r_rd_ready        <= '0;
      r_wr_ready        <= '0;
      r_rd_data         <= '0;
    end else begin
      r_rd_ready <= '0;
      r_wr_ready <= '0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant_found) begin
            r_idx             <= w_grant_idx;
            r_ptr             <= w_grant_idx;
            r_is_wr           <= w_grant_is_wr;
            r_addr            <= w_grant_addr;
            r_wdata           <= w_grant_wdata;
            r_mem_write_valid <= w_grant_is_wr;
            r_mem_read_valid  <= !w_grant_is_wr;
          end
        end
        S_MEM_RD: begin
          if (mem_read_ready) begin
            r_mem_read_valid  <= 1'b0;
            r_rd_ready[r_idx] <= 1'b1;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
              if (IDX_W'(i) == r_idx) r_rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
            end
          end
        end
        S_MEM_WR: begin
          if (mem_write_ready) begin
            r_mem_write_valid <= 1'b0;
            r_wr_ready[r_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_MEM_ARB_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_stall;

  // Activity counters: completed reads/writes and memory stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (r_state == S_RESPOND && !r_is_wr) r_stat_reads  <= r_stat_reads + 32'd1;
      if (r_state == S_RESPOND &&  r_is_wr) r_stat_writes <= r_stat_writes + 32'd1;
      if ((r_state == S_MEM_RD && !mem_read_ready) || (r_state == S_MEM_WR && !mem_write_ready))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_stall  = r_stat_stall;
`endif

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_write_ready = r_wr_ready;
  assign consumer_read_data   = r_rd_data;
  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_addr;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_addr;
  assign mem_write_data       = r_wdata;
  assign busy                 = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic for
// data_mem_arbiter, checked every cycle against a transaction-level model.
module tb_data_mem_arbiter;
  localparam int N  = 17;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]    rv, wv, rr, wr_rdy;
  logic [N*AW-1:0] ra, wa;
  logic [N*DW-1:0] wd, rdata;
  logic            mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready, busy;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_read_data, mem_write_data;
`ifdef DATA_MEM_ARB_STATS_EN
  logic [31:0]     stat_reads, stat_writes, stat_stall;
`endif

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr), .consumer_read_data(rdata),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wr_rdy),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
`ifdef DATA_MEM_ARB_STATS_EN
    .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_stall(stat_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unwritten memory words hold an address-derived pattern
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory device (driven from the DUT bus) and reference memory (from consumer intent)
  logic [31:0] mem_dev [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return mem_dev.exists(a) ? mem_dev[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (!reset && mem_write_valid && mem_write_ready) mem_dev[mem_write_address] = mem_write_data;
  end

  // Transaction-level model: phase 0 waiting, 1 memory access, 2 ack, 3 waiting for drop
  int              m_phase, m_ptr, m_idx;
  logic            m_wr, m_found;
  logic [31:0]     m_addr, m_data;
  logic [N*DW-1:0] exp_rd;
  logic [31:0]     m_reads, m_writes, m_stall;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_ptr = N - 1; m_idx = 0; m_wr = 0; m_addr = 0; m_data = 0;
      exp_rd = '0; m_reads = 0; m_writes = 0; m_stall = 0;
    end else begin
      case (m_phase)
        0: begin
          m_found = 0;
          for (int k = 1; k <= N; k++) begin
            if (!m_found && (rv[(m_ptr + k) % N] || wv[(m_ptr + k) % N])) begin
              m_found = 1;
              m_idx   = (m_ptr + k) % N;
            end
          end
          if (m_found) begin
            m_ptr   = m_idx;
            m_wr    = wv[m_idx];
            m_addr  = m_wr ? wa[m_idx*AW +: AW] : ra[m_idx*AW +: AW];
            m_data  = wd[m_idx*DW +: DW];
            m_phase = 1;
          end
        end
        1: begin
          if (m_wr ? mem_write_ready : mem_read_ready) begin
            if (m_wr) ref_mem[m_addr] = m_data;
            else      exp_rd[m_idx*DW +: DW] = ref_read(m_addr);
            m_phase = 2;
          end else begin
            m_stall = m_stall + 1;
          end
        end
        2: begin
          if (m_wr) m_writes = m_writes + 1;
          else      m_reads  = m_reads + 1;
          m_phase = 3;
        end
        default: if (!(m_wr ? wv[m_idx] : rv[m_idx])) m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, plus issue log and valid-length tracking
  logic [N-1:0] e_rr, e_wr;
  logic [32:0]  issue_q [$];
  logic         prev_mrv = 0, prev_mwv = 0;
  int           vlen_cur = 0, last_vlen = 0;

  always @(negedge clk) begin
    e_rr = '0; e_wr = '0;
    if (m_phase == 2) begin
      if (m_wr) e_wr[m_idx] = 1'b1;
      else      e_rr[m_idx] = 1'b1;
    end
    chk("busy", busy, m_phase != 0);
    chk("mem_read_valid", mem_read_valid, m_phase == 1 && !m_wr);
    chk("mem_write_valid", mem_write_valid, m_phase == 1 && m_wr);
    if (m_phase == 1 && !m_wr) chk("mem_read_address", mem_read_address, m_addr);
    if (m_phase == 1 && m_wr) begin
      chk("mem_write_address", mem_write_address, m_addr);
      chk("mem_write_data", mem_write_data, m_data);
    end
    chk("read_ready", rr, e_rr);
    chk("write_ready", wr_rdy, e_wr);
    chk("read_data", rdata, exp_rd);
`ifdef DATA_MEM_ARB_STATS_EN
    chk("stat_reads", stat_reads, m_reads);
    chk("stat_writes", stat_writes, m_writes);
    chk("stat_stall", stat_stall, m_stall);
`endif
    if (mem_read_valid && !prev_mrv)  issue_q.push_back({1'b0, mem_read_address});
    if (mem_write_valid && !prev_mwv) issue_q.push_back({1'b1, mem_write_address});
    if (mem_read_valid || mem_write_valid) vlen_cur++;
    else if (prev_mrv || prev_mwv) begin last_vlen = vlen_cur; vlen_cur = 0; end
    prev_mrv = mem_read_valid;
    prev_mwv = mem_write_valid;
  end

  function automatic logic [32:0] qat(input int k);
    return (issue_q.size() > k) ? issue_q[k] : 33'h1_FFFF_FFFF;
  endfunction

  // Stimulus controls
  int ready_mode = 1;   // 0 random ready, 1 ready after stall_n cycles of valid
  int stall_n    = 0;
  int vage       = 0;
  int hold_max   = 0;
  int rand_en    = 0;
  int rd_drop [N], wr_drop [N], rd_cool [N], wr_cool [N];

  task automatic clear_stim();
    rv = '0; wv = '0;
    for (int i = 0; i < N; i++) begin rd_drop[i] = -1; wr_drop[i] = -1; rd_cool[i] = 0; wr_cool[i] = 0; end
  endtask

  // One clock: consumers react to acks / make requests, memory answers
  task automatic step();
    logic rdy;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (rd_cool[i] > 0) rd_cool[i]--;
      if (wr_cool[i] > 0) wr_cool[i]--;
      if (rr[i])     rd_drop[i] = $urandom_range(0, hold_max);
      if (wr_rdy[i]) wr_drop[i] = $urandom_range(0, hold_max);
      if (rd_drop[i] == 0) begin rv[i] = 1'b0; rd_drop[i] = -1; rd_cool[i] = 2; end
      else if (rd_drop[i] > 0) rd_drop[i]--;
      if (wr_drop[i] == 0) begin wv[i] = 1'b0; wr_drop[i] = -1; wr_cool[i] = 2; end
      else if (wr_drop[i] > 0) wr_drop[i]--;
      if (rand_en != 0) begin
        if (!rv[i] && rd_drop[i] < 0 && rd_cool[i] == 0 && $urandom_range(0, 7) == 0) begin
          rv[i] = 1'b1; ra[i*AW +: AW] = 32'($urandom_range(0, 15) * 4);
        end else if (rv[i] && $urandom_range(0, 3) == 0) ra[i*AW +: AW] = 32'($urandom_range(0, 15) * 4);
        if (!wv[i] && wr_drop[i] < 0 && wr_cool[i] == 0 && $urandom_range(0, 9) == 0) begin
          wv[i] = 1'b1; wa[i*AW +: AW] = 32'($urandom_range(0, 15) * 4); wd[i*DW +: DW] = $urandom;
        end else if (wv[i] && $urandom_range(0, 3) == 0) begin
          wa[i*AW +: AW] = 32'($urandom_range(0, 15) * 4); wd[i*DW +: DW] = $urandom;
        end
      end
    end
    if (mem_read_valid || mem_write_valid) begin
      rdy = (ready_mode == 1) ? (vage >= stall_n) : ($urandom_range(0, 9) < 6);
      vage++;
    end else begin
      vage = 0;
      rdy  = (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 6);
    end
    mem_read_ready  = rdy;
    mem_write_ready = rdy;
    mem_read_data   = dev_read(mem_read_address);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (n < max_cycles && !(rv == '0 && wv == '0 && !busy)) begin step(); n++; end
    if (!(rv == '0 && wv == '0 && !busy)) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b rv=%0h wv=%0h after %0d cycles", busy, rv, wv, max_cycles);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    clear_stim();
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    ra = '0; wa = '0; wd = '0;
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;
    clear_stim();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_read_valid", mem_read_valid, 1'b0);
    chk("rst_mem_write_valid", mem_write_valid, 1'b0);
    chk("rst_read_ready", rr, '0);
    chk("rst_write_ready", wr_rdy, '0);
    chk("rst_read_data", rdata, '0);
    chk("rst_mem_address", mem_read_address, 32'h0);
    step();
    reset = 1'b0;

    // Single read: consumer 3 reads 0x40, no stall
    mem_dev[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    step();
    rv[3] = 1'b1; ra[3*AW +: AW] = 32'h40;
    @(negedge clk);
    chk("sr_busy_grant_cycle", busy, 1'b0);
    step();
    @(negedge clk);
    chk("sr_mem_valid_t1", mem_read_valid, 1'b1);
    chk("sr_mem_addr_t1", mem_read_address, 32'h40);
    step();
    @(negedge clk);
    chk("sr_ack_t2", rr, 17'h00008);
    chk("sr_data3", rdata[3*DW +: DW], 32'hDEADBEEF);
    wait_idle(50);

    // Round robin from a fresh pointer: 0, 5, 16 then 0 again
    pulse_reset();
    issue_q.delete();
    rv[0] = 1; ra[0*AW +: AW] = 32'h0;
    rv[5] = 1; ra[5*AW +: AW] = 32'h50;
    rv[16] = 1; ra[16*AW +: AW] = 32'h160;
    for (int n = 0; n < 200 && issue_q.size() < 2; n++) step();
    repeat (3) step();
    rv[0] = 1; ra[0*AW +: AW] = 32'h4;
    wait_idle(300);
    chk("rr_count", issue_q.size(), 4);
    chk("rr_0", qat(0), {1'b0, 32'h0});
    chk("rr_1", qat(1), {1'b0, 32'h50});
    chk("rr_2", qat(2), {1'b0, 32'h160});
    chk("rr_3", qat(3), {1'b0, 32'h4});

    // Wrap: pointer at 16, consumers 16 and 2 -> 2 first
    step();
    rv[16] = 1; ra[16*AW +: AW] = 32'h160;
    wait_idle(100);
    issue_q.delete();
    step();
    rv[16] = 1; ra[16*AW +: AW] = 32'h164;
    rv[2] = 1;  ra[2*AW +: AW]  = 32'h200;
    wait_idle(200);
    chk("wrap_0", qat(0), {1'b0, 32'h200});
    chk("wrap_1", qat(1), {1'b0, 32'h164});

    // Read and write from consumer 7: write served first
    issue_q.delete();
    step();
    wv[7] = 1; wa[7*AW +: AW] = 32'h10; wd[7*DW +: DW] = 32'h55;
    rv[7] = 1; ra[7*AW +: AW] = 32'h10;
    wait_idle(200);
    chk("rw_first_write", qat(0), {1'b1, 32'h10});
    chk("rw_then_read", qat(1), {1'b0, 32'h10});
    chk("rw_data7", rdata[7*DW +: DW], 32'h55);

    // Stall: memory ready 5 cycles late
    pulse_reset();
    stall_n = 5;
    step();
    rv[1] = 1; ra[1*AW +: AW] = 32'h24;
    wait_idle(100);
    chk("stall_valid_len", last_vlen, 6);
`ifdef DATA_MEM_ARB_STATS_EN
    chk("stall_stat_stall", stat_stall, 32'd5);
    chk("stall_stat_reads", stat_reads, 32'd1);
`endif

    // Reset during a write access
    stall_n = 1000;
    step();
    wv[4] = 1; wa[4*AW +: AW] = 32'h30; wd[4*DW +: DW] = 32'h99;
    repeat (3) step();
    @(negedge clk);
    chk("mid_wr_valid_before", mem_write_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_wr_valid_after", mem_write_valid, 1'b0);
    chk("mid_busy_after", busy, 1'b0);
    chk("mid_read_data_after", rdata, '0);
    chk("mid_addr_after", mem_write_address, 32'h0);
    clear_stim();
    stall_n = 0;
    step(); step();
    reset = 1'b0;
    issue_q.delete();
    rv[9] = 1; ra[9*AW +: AW] = 32'h90;
    rv[0] = 1; ra[0*AW +: AW] = 32'h8;
    wait_idle(200);
    chk("post_reset_first", qat(0), {1'b0, 32'h8});
    chk("post_reset_second", qat(1), {1'b0, 32'h90});

    // Randomized traffic with random stalls and delayed releases
    ready_mode = 0;
    hold_max   = 3;
    rand_en    = 1;
    repeat (4000) step();
    rand_en = 0;
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
